jk_flip_flop: RTL and testbench
===============================

// Module: jk_flip_flop
//
// PURPOSE
//   Edge-triggered JK flip-flop bank with an asynchronous, active-low clear.
//   Implements hold / reset / set / toggle on each rising clock edge.
//   Used as a basic sequential storage and toggle element in lab-level datapaths.
//   WIDTH independent bits share one clock and one reset.
//
// PARAMETERS
//   WIDTH      1     number of independent JK bits (q, j, k are WIDTH wide)
//   RESET_VAL  0     value forced onto q while reset is low (WIDTH bits)
//
// PORTS
//   clk    in   1      clock; all state changes on rising edge
//   reset  in   1      asynchronous, active-low reset (0 = clear)
//   q      out  WIDTH  registered flip-flop state
//   j      in   WIDTH  J input (set request), per bit
//   k      in   WIDTH  K input (reset request), per bit
//   qn     out  WIDTH  ~q; present only when JK_FF_QN_EN is defined
//   Declaration order is (q, clk, reset, j, k[, qn]) for positional instantiation.
//
// BEHAVIOUR
//   - One clock (clk, rising edge); reset is asynchronous and active-low.
//   - reset=0: q <= RESET_VAL immediately, without waiting for clk.
//     Held for as long as reset stays low; clk, j and k are ignored.
//   - reset=1, on posedge clk, per bit i:
//       j=0 k=0 : q[i] holds
//       j=0 k=1 : q[i] <= 0
//       j=1 k=0 : q[i] <= 1
//       j=1 k=1 : q[i] <= ~q[i]  (toggle)
//   - Latency: one clock edge from j/k sample to q update.
//     j and k are sampled at the edge; changes between edges have no effect.
//   - Reset release coincident with a clock edge: that edge is ignored.
//     The first active edge is the next one after reset is high.
//   - Reset asserted mid-toggle sequence: q clears at once.
//     The toggle resumes from RESET_VAL after release.
//   - X/Z on j or k: q takes X; no X-squashing required.
//   - Bits are fully independent; no cross-bit interaction.
//
// CONFIGURATION
//   JK_FF_QN_EN defined : extra output port qn = ~q (combinational from q).
//     During reset, qn = ~RESET_VAL.
//   JK_FF_QN_EN undefined : port qn does not exist; the port list is exactly
//     (q, clk, reset, j, k).
//
// TESTING
//   1. reset=0 from t=0, toggle clk with j/k=11 -> q=0 throughout.
//   2. reset=1, j=1 k=0, one posedge -> q=1.
//      Then j=0 k=0 for 3 edges -> q stays 1.
//   3. q=1, j=0 k=1, one posedge -> q=0.
//      Repeat the edge -> q stays 0.
//   4. q=0, j=1 k=1 for 4 posedges -> q = 1,0,1,0.
//   5. q=1, drop reset to 0 between clock edges -> q=0 before the next edge.
//      Release with j=1 k=1 -> first edge after release gives q=1.
//   6. Sweep {j,k} = 00,01,10,11 every 3 clock edges with reset high:
//      - compare q against the truth table on every edge;
//      - with JK_FF_QN_EN defined, check qn == ~q on every edge.

Source files
------------

// File: rtl/jk_flip_flop.sv
// -----------------------------------------------------------------------------
// jk_flip_flop
//
// Purpose:
//    A bank of WIDTH independent edge-triggered JK flip-flops. They share one
//    clock and one asynchronous, active-low clear. On each rising clock edge
//    every bit independently holds, resets, sets or toggles, depending on its
//    own j/k pair.
//
// Parameters:
//    WIDTH      number of independent JK bits
//    RESET_VAL  value forced onto q while reset is low
//
// Ports (declaration order q, clk, reset, j, k[, qn]):
//    q      out  WIDTH  registered flip-flop state
//    clk    in   1      clock, rising-edge active
//    reset  in   1      asynchronous clear, active-low (0 = clear)
//    j      in   WIDTH  per-bit set request
//    k      in   WIDTH  per-bit reset request
//    qn     out  WIDTH  complement of q (only with JK_FF_QN_EN)
//
// Configuration macro:
//    JK_FF_QN_EN  when defined, adds the qn output (combinational ~q).
//                 When undefined, the port list is exactly (q, clk, reset, j, k).
// -----------------------------------------------------------------------------
module jk_flip_flop #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   output logic [WIDTH-1:0] q,
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k
`ifdef JK_FF_QN_EN
   ,
   output logic [WIDTH-1:0] qn
`endif
);

   logic [WIDTH-1:0] next_q;

   // The characteristic equation Q+ = J.~Q + ~K.Q covers all four j/k cases
   // for every bit at once: 00 holds, 01 clears, 10 sets, 11 toggles.
   // X on j or k propagates into next_q on purpose; no X-squashing is done.
   always_comb begin
      next_q = (j & ~q) | (~k & q);
   end

   // The state register. A low reset forces RESET_VAL immediately and keeps it
   // there, whatever clk, j and k do. An edge that coincides with the release of
   // reset still sees reset low, so it is ignored. The first edge that can
   // change q is the next one after reset is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RESET_VAL;
      end else begin
         q <= next_q;
      end
   end

`ifdef JK_FF_QN_EN
   // The complement is derived from q itself, so during reset it reads
   // ~RESET_VAL with no extra logic.
   assign qn = ~q;
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// -----------------------------------------------------------------------------
// tb_jk_flip_flop
//
// Drives a 4-bit jk_flip_flop instance with a non-zero reset value. The
// stimulus process issues j/k (and reset) and queues the state that a
// behavioural truth-table model predicts. An independent monitor pops one
// entry at each clock edge or reset assertion and compares it with q (and qn
// when JK_FF_QN_EN is defined).
// -----------------------------------------------------------------------------
module tb_jk_flip_flop;

   localparam int         W  = 4;
   localparam logic [3:0] RV = 4'b0101;

   typedef struct {
      logic [W-1:0] exp;
      string        tag;
   } sb_entry_t;

   logic         clk;
   logic         reset;
   logic [W-1:0] j;
   logic [W-1:0] k;
   logic [W-1:0] q;
`ifdef JK_FF_QN_EN
   logic [W-1:0] qn;
`endif

   sb_entry_t    sb_q[$];
   logic [W-1:0] model;
   int           checks_total;
   int           checks_passed;

   jk_flip_flop #(
      .WIDTH    (W),
      .RESET_VAL(RV)
   ) dut (
      .q    (q),
      .clk  (clk),
      .reset(reset),
      .j    (j),
      .k    (k)
`ifdef JK_FF_QN_EN
      ,
      .qn   (qn)
`endif
   );

   // Free-running clock with a period of 10 time units. Rising edges fall at
   // 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the JK truth table applied to each bit on its own.
   function automatic logic [W-1:0] jkRule(input logic [W-1:0] cur,
                                           input logic [W-1:0] jv,
                                           input logic [W-1:0] kv);
      logic [W-1:0] nxt;
      for (int i = 0; i < W; i++) begin
         case ({jv[i], kv[i]})
            2'b00:   nxt[i] = cur[i];
            2'b01:   nxt[i] = 1'b0;
            2'b10:   nxt[i] = 1'b1;
            default: nxt[i] = (cur[i] == 1'b1) ? 1'b0 : 1'b1;
         endcase
      end
      return nxt;
   endfunction

   // One comparison of q (and qn when present) against a queued expectation.
   task automatic checkOutput(input sb_entry_t e);
      checks_total++;
      if (q === e.exp) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: q=%b expected=%b at t=%0t", e.tag, q, e.exp, $time);
      end
`ifdef JK_FF_QN_EN
      checks_total++;
      if (qn === ~e.exp) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s_qn: qn=%b expected=%b at t=%0t", e.tag, qn, ~e.exp, $time);
      end
`endif
   endtask

   // Monitor: samples 1 time unit after every rising edge and after every
   // reset assertion, and compares against the oldest queued expectation.
   initial begin
      forever begin
         @(posedge clk or negedge reset);
         #1;
         if (sb_q.size() > 0) begin
            checkOutput(sb_q.pop_front());
         end
      end
   end

   // Drives j/k at the falling edge, updates the model for the coming rising
   // edge, and queues the prediction.
   task automatic applyStimulus(input logic [W-1:0] jv, input logic [W-1:0] kv,
                                input string tag);
      sb_entry_t e;
      @(negedge clk);
      j = jv;
      k = kv;
      if (reset == 1'b1) begin
         model = jkRule(model, jv, kv);
      end else begin
         model = RV;
      end
      e.exp = model;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   // Asserts reset 2 time units after a rising edge, well away from any edge.
   task automatic assertResetMidCycle(input string tag);
      sb_entry_t e;
      @(posedge clk);
      #2;
      model = RV;
      e.exp = model;
      e.tag = tag;
      sb_q.push_back(e);
      reset = 1'b0;
   endtask

   // Releases reset at a falling edge with the j/k values for the first edge.
   task automatic releaseReset(input logic [W-1:0] jv, input logic [W-1:0] kv,
                               input string tag);
      sb_entry_t e;
      @(negedge clk);
      reset = 1'b1;
      j     = jv;
      k     = kv;
      model = jkRule(RV, jv, kv);
      e.exp = model;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   initial begin
      logic [1:0]   pat;
      logic [W-1:0] rj;
      logic [W-1:0] rk;
      checks_total  = 0;
      checks_passed = 0;
      reset = 1'b0;
      j     = '1;
      k     = '1;
      model = RV;

      // Held in reset with toggle requests: q must stay at the reset value.
      for (int n = 0; n < 4; n++) begin
         applyStimulus('1, '1, "reset_hold");
      end

      // Release, then set and hold.
      releaseReset('1, '0, "set_after_release");
      for (int n = 0; n < 3; n++) begin
         applyStimulus('0, '0, "hold_one");
      end

      // Clear twice.
      for (int n = 0; n < 2; n++) begin
         applyStimulus('0, '1, "clear");
      end

      // Toggle four times from zero: 1,0,1,0.
      for (int n = 0; n < 4; n++) begin
         applyStimulus('1, '1, "toggle");
      end

      // From all ones, assert reset between edges, then release while toggling.
      applyStimulus('1, '0, "set_before_reset");
      assertResetMidCycle("async_clear");
      releaseReset('1, '1, "toggle_from_reset");
      applyStimulus('1, '1, "toggle_after_reset");

      // Sweep all four j/k codes on every bit, three edges each.
      for (int p = 0; p < 4; p++) begin
         pat = p[1:0];
         for (int n = 0; n < 3; n++) begin
            applyStimulus({W{pat[1]}}, {W{pat[0]}}, "sweep");
         end
      end

      // Random per-bit j/k. Mid-cycle values are junk that must be ignored.
      // Occasionally an asynchronous reset pulse is inserted.
      for (int n = 0; n < 60; n++) begin
         rj = W'($urandom_range(0, 15));
         rk = W'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) begin
            assertResetMidCycle("rand_async_clear");
            releaseReset(rj, rk, "rand_release");
         end else begin
            applyStimulus(rj, rk, "random");
            @(posedge clk);
            #2;
            j = W'($urandom_range(0, 15));
            k = W'($urandom_range(0, 15));
         end
      end

      // Let the monitor drain the queue; anything left over counts as a miss.
      for (int n = 0; n < 4 && sb_q.size() > 0; n++) begin
         @(negedge clk);
      end
      if (sb_q.size() != 0) begin
         checks_total++;
         $display("[TB] FAIL drain: pending=%0d expected=0", sb_q.size());
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
